stream_fifo: RTL and testbench

Parametrised successor to the team's single-port-pair FIFO.
- Synchronous FIFO with a valid/ready stream handshake on both sides and first-word-fall-through output.
- Supports any DEPTH, including non-power-of-two, plus an occupancy count, almost-full/almost-empty thresholds and a synchronous flush.
- Sits between the AXI-stream slave front end and the AES core, buffering 128-bit blocks in both directions.

---
 rtl/stream_fifo.sv | 94 +++++++++
 tb/tb_stream_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// Synchronous valid/ready stream FIFO with first-word-fall-through output,
// arbitrary (non-power-of-two) depth, occupancy count, threshold flags and flush.
module stream_fifo #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 11,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 1,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   input  logic                  flush,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam int                    PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0]  PTR_LAST  = PTR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0]  AF_CNT    = CNT_WIDTH'(AF_LEVEL);
   localparam logic [CNT_WIDTH-1:0]  AE_CNT    = CNT_WIDTH'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
   logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  doWrite;
   logic                  doRead;

   // Pointers wrap explicitly at DEPTH-1 so any depth works; full/empty come from count.
   function automatic logic [PTR_WIDTH-1:0] ptrNext(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full    = (count_q == CNT_FULL);
   assign fifo_empty   = (count_q == '0);
   assign in_ready     = !fifo_full;
   assign out_valid    = !fifo_empty;
   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign count        = count_q;
   assign out_data     = mem_q[rptr_q];

   assign doWrite = in_valid && in_ready;
   assign doRead  = out_valid && out_ready;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (doWrite) wptr_d = ptrNext(wptr_q);
         if (doRead)  rptr_d = ptrNext(rptr_q);
         case ({doWrite, doRead})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left unreset; a flushed write must not land either.
   always_ff @(posedge clk) begin
      if (doWrite && !flush && !reset) begin
         mem_q[wptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_stream_fifo.sv
// Randomized bench for stream_fifo comparing against a queue-based model of the FIFO.
module tb_stream_fifo;

   localparam int DW    = 128;
   localparam int DEPTH = 11;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          flush;
   logic [CW-1:0] count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          almost_full;
   logic          almost_empty;

   int assertCount = 0;
   int failCount   = 0;

   logic [DW-1:0] model[$];

   stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .flush(flush), .count(count),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .almost_full(almost_full), .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Advance one clock edge and apply the queue model's view of that edge.
   task automatic tick();
      bit            w, r, f;
      logic [DW-1:0] d;
      w = in_valid && (model.size() < DEPTH);
      r = out_ready && (model.size() > 0);
      f = flush;
      d = in_data;
      @(posedge clk);
      #1;
      if (f) model.delete();
      else begin
         if (r) void'(model.pop_front());
         if (w) model.push_back(d);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model.delete();
      @(negedge clk);
      assertCount++;
      if (count !== 4'd0) begin failCount++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      assertCount++;
      if ({fifo_empty, in_ready, out_valid, almost_empty, almost_full, fifo_full} !== 6'b110100) begin
         failCount++;
         $display("[TB] FAIL reset_flags: got empty=%b in_ready=%b out_valid=%b ae=%b af=%b full=%b expected 1 1 0 1 0 0",
                  fifo_empty, in_ready, out_valid, almost_empty, almost_full, fifo_full);
      end
   endtask

   task automatic test_fill();
      out_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         in_valid = 1'b1; in_data = rnd();
         tick();
         assertCount++;
         if (count !== CW'(i)) begin failCount++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, i); end
         assertCount++;
         if (almost_full !== (i >= 9)) begin failCount++; $display("[TB] FAIL fill_almost_full: got %b expected %b at count %0d", almost_full, (i >= 9), i); end
         assertCount++;
         if (fifo_full !== (i == DEPTH) || in_ready !== (i != DEPTH)) begin
            failCount++;
            $display("[TB] FAIL fill_full: got full=%b in_ready=%b expected %b %b", fifo_full, in_ready, (i == DEPTH), (i != DEPTH));
         end
         assertCount++;
         if (out_valid !== 1'b1 || out_data !== model[0]) begin failCount++; $display("[TB] FAIL fill_head: got %h expected %h", out_data, model[0]); end
      end
      in_data = rnd();
      tick();
      assertCount++;
      if (count !== CW'(DEPTH) || model.size() != DEPTH) begin failCount++; $display("[TB] FAIL fill_overflow: got %0d expected %0d", count, DEPTH); end
      in_valid = 1'b0;
   endtask

   task automatic test_drain();
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         assertCount++;
         if (out_valid !== 1'b1 || out_data !== model[0]) begin
            failCount++;
            $display("[TB] FAIL drain_order[%0d]: got valid=%b data=%h expected 1 %h", i, out_valid, out_data, model[0]);
         end
         tick();
      end
      assertCount++;
      if (fifo_empty !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0) begin
         failCount++;
         $display("[TB] FAIL drain_empty: got empty=%b valid=%b count=%0d expected 1 0 0", fifo_empty, out_valid, count);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_streaming();
      in_valid = 1'b1; out_ready = 1'b0; in_data = rnd();
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         in_data = rnd();
         assertCount++;
         if (out_valid !== 1'b1 || out_data !== model[0]) begin
            failCount++;
            $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, out_data, model[0]);
         end
         tick();
         assertCount++;
         if (count !== 4'd1) begin failCount++; $display("[TB] FAIL stream_count[%0d]: got %0d expected 1", i, count); end
      end
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_full_rw();
      logic [DW-1:0] offered;
      out_ready = 1'b0;
      for (int i = 0; i < 2 * DEPTH && model.size() < DEPTH; i++) begin
         in_valid = 1'b1; in_data = rnd();
         tick();
      end
      assertCount++;
      if (count !== CW'(DEPTH)) begin failCount++; $display("[TB] FAIL fullrw_setup: got %0d expected %0d", count, DEPTH); end
      offered = rnd();
      in_valid = 1'b1; in_data = offered; out_ready = 1'b1;
      tick();
      assertCount++;
      if (count !== CW'(DEPTH - 1) || in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL fullrw_read_only: got count=%0d in_ready=%b expected %0d 1", count, in_ready, DEPTH - 1);
      end
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      assertCount++;
      if (count !== CW'(DEPTH) || model[DEPTH-1] !== offered) begin
         failCount++;
         $display("[TB] FAIL fullrw_late_write: got count=%0d expected %0d", count, DEPTH);
      end
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2 && model.size() > 0; i++) begin
         assertCount++;
         if (out_data !== model[0]) begin failCount++; $display("[TB] FAIL fullrw_drain[%0d]: got %h expected %h", i, out_data, model[0]); end
         tick();
      end
      assertCount++;
      if (fifo_empty !== 1'b1) begin failCount++; $display("[TB] FAIL fullrw_empty: got %b expected 1", fifo_empty); end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      logic [DW-1:0] word;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = rnd(); tick(); end
      flush = 1'b1; in_data = rnd();
      tick();
      flush = 1'b0; in_valid = 1'b0;
      assertCount++;
      if (count !== 4'd0 || fifo_empty !== 1'b1 || out_valid !== 1'b0 || almost_empty !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL flush_clear: got count=%0d empty=%b valid=%b ae=%b expected 0 1 0 1", count, fifo_empty, out_valid, almost_empty);
      end
      word = rnd();
      in_valid = 1'b1; in_data = word;
      tick();
      in_valid = 1'b0;
      assertCount++;
      if (count !== 4'd1 || out_valid !== 1'b1 || out_data !== word) begin
         failCount++;
         $display("[TB] FAIL flush_refill: got count=%0d data=%h expected 1 %h", count, out_data, word);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = rnd(); tick(); end
      in_valid = 1'b0;
      assertCount++;
      if (count !== 4'd3) begin failCount++; $display("[TB] FAIL midreset_setup: got %0d expected 3", count); end
      #2 reset = 1'b1;
      #1;
      model.delete();
      assertCount++;
      if (count !== 4'd0 || {fifo_empty, in_ready, out_valid, almost_empty, almost_full, fifo_full} !== 6'b110100) begin
         failCount++;
         $display("[TB] FAIL midreset_async: got count=%0d empty=%b in_ready=%b valid=%b ae=%b af=%b full=%b expected 0 1 1 0 1 0 0",
                  count, fifo_empty, in_ready, out_valid, almost_empty, almost_full, fifo_full);
      end
      @(posedge clk); #1 reset = 1'b0;
      in_valid = 1'b1; in_data = rnd();
      tick();
      in_valid = 1'b0;
      assertCount++;
      if (count !== 4'd1 || out_data !== model[0]) begin
         failCount++;
         $display("[TB] FAIL midreset_recover: got count=%0d data=%h expected 1 %h", count, out_data, model[0]);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_full_rw();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
